// File: rtl/vend_controller.sv
// Vending transaction sequencer: credits coins, runs the dispense handshake and returns change/refunds.
// Optional inactivity refund while holding credit is enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
    parameter int PRICE0         = 3,
    parameter int PRICE1         = 5,
    parameter int PRICE2         = 7,
    parameter int PRICE3         = 10,
    parameter int MAX_CREDIT     = 50,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_pulse,
    input  logic [7:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    input  logic       vend_ack,
    output logic [7:0] credit,
    output logic       vend_req,
    output logic [1:0] vend_item,
    output logic       change_pulse,
    output logic [7:0] change_value,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t     r_state;
    logic [7:0] r_credit;
    logic       r_vendReq;
    logic [1:0] r_vendItem;
    logic       r_changePulse;
    logic [7:0] r_changeValue;
    logic       r_coinReject;
    logic       r_insufficient;
    logic       r_busy;

    logic [8:0] w_sum;
    logic       w_coinOk;
    logic [7:0] w_coinAdd;
    logic [7:0] w_price;
    logic       w_timeout;
    logic       w_cancel;

    // Coins are only credited while no transaction is in flight and the ceiling is respected.
    assign w_sum     = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_coinOk  = coin_pulse && ((r_state == IDLE) || (r_state == CREDIT))
                       && (w_sum <= 9'(MAX_CREDIT));
    assign w_coinAdd = w_coinOk ? coin_value : 8'd0;
    assign w_cancel  = cancel || w_timeout;

    always_comb begin
        w_price = 8'(PRICE0);
        case (sel_item)
            2'd0: w_price = 8'(PRICE0);
            2'd1: w_price = 8'(PRICE1);
            2'd2: w_price = 8'(PRICE2);
            2'd3: w_price = 8'(PRICE3);
            default: w_price = 8'(PRICE0);
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    logic [15:0] r_timer;

    assign w_timeout = (r_state == CREDIT) && (r_timer == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if ((r_state != CREDIT) || coin_pulse || sel_valid || cancel || w_timeout) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Strobes default low each cycle; a cancel outranks a selection in CREDIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_credit       <= 8'd0;
            r_vendReq      <= 1'b0;
            r_vendItem     <= 2'd0;
            r_changePulse  <= 1'b0;
            r_changeValue  <= 8'd0;
            r_coinReject   <= 1'b0;
            r_insufficient <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_changePulse  <= 1'b0;
            r_changeValue  <= 8'd0;
            r_coinReject   <= coin_pulse && !w_coinOk;
            r_insufficient <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_coinOk) begin
                        r_credit <= w_sum[7:0];
                        if (coin_value != 8'd0) begin
                            r_state <= CREDIT;
                        end
                    end
                    if (sel_valid) begin
                        r_insufficient <= 1'b1;
                    end
                end
                CREDIT: begin
                    if (w_cancel) begin
                        r_changePulse <= 1'b1;
                        r_changeValue <= r_credit + w_coinAdd;
                        r_credit      <= 8'd0;
                        r_busy        <= 1'b1;
                        r_state       <= CHANGE;
                    end else if (sel_valid && (r_credit >= w_price)) begin
                        r_credit   <= r_credit - w_price + w_coinAdd;
                        r_vendItem <= sel_item;
                        r_vendReq  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= VEND;
                    end else begin
                        r_credit <= r_credit + w_coinAdd;
                        if (sel_valid) begin
                            r_insufficient <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    if (vend_ack) begin
                        r_vendReq <= 1'b0;
                        if (r_credit != 8'd0) begin
                            r_changePulse <= 1'b1;
                            r_changeValue <= r_credit;
                            r_credit      <= 8'd0;
                            r_state       <= CHANGE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                CHANGE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign credit       = r_credit;
    assign vend_req     = r_vendReq;
    assign vend_item    = r_vendItem;
    assign change_pulse = r_changePulse;
    assign change_value = r_changeValue;
    assign coin_reject  = r_coinReject;
    assign insufficient = r_insufficient;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model predicts every output cycle,
// a separate monitor pops and compares after each rising edge.
module tb_vend_controller;

`ifdef VEND_TIMEOUT_EN
    localparam int TB_TIMEOUT = 20;
`else
    localparam int TB_TIMEOUT = 1000;
`endif
    localparam int MAXC = 50;

    logic       clk;
    logic       rst_n;
    logic       coin_pulse;
    logic [7:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       vend_ack;
    logic [7:0] credit;
    logic       vend_req;
    logic [1:0] vend_item;
    logic       change_pulse;
    logic [7:0] change_value;
    logic       coin_reject;
    logic       insufficient;
    logic       busy;

    vend_controller #(
        .PRICE0(3), .PRICE1(5), .PRICE2(7), .PRICE3(10),
        .MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_pulse(coin_pulse), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_item(sel_item),
        .cancel(cancel), .vend_ack(vend_ack),
        .credit(credit), .vend_req(vend_req), .vend_item(vend_item),
        .change_pulse(change_pulse), .change_value(change_value),
        .coin_reject(coin_reject), .insufficient(insufficient), .busy(busy)
    );

    typedef struct {
        int credit;
        int vreq;
        int vitem;
        int cpulse;
        int cvalue;
        int reject;
        int insuf;
        int busy;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   prices[4] = '{3, 5, 7, 10};

    // Reference model: a wallet balance plus "dispensing" and "returning change" flags
    int mCredit;
    bit mVending;
    bit mReturning;
    int mItem;
    int mIdle;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        nChecks++;
        if (act != expv) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelReset();
        mCredit    = 0;
        mVending   = 0;
        mReturning = 0;
        mItem      = 0;
        mIdle      = 0;
    endtask

    function automatic exp_t zeroExp();
        exp_t e;
        e.credit = 0; e.vreq = 0; e.vitem = 0; e.cpulse = 0;
        e.cvalue = 0; e.reject = 0; e.insuf = 0; e.busy = 0;
        return e;
    endfunction

    // Predict what the outputs must show after the next rising edge, given this cycle's inputs.
    task automatic modelStep(input bit c, input int v, input bit s, input int it, input bit k, input bit a);
        exp_t e;
        bit   accept;
        int   add;
        bit   holding;
        bit   tmo;
        e = zeroExp();
        holding = !mVending && !mReturning && (mCredit > 0);
        tmo = 0;
`ifdef VEND_TIMEOUT_EN
        tmo = holding && (mIdle == TB_TIMEOUT - 1);
`endif
        if (mReturning) begin
            e.reject   = c;
            mReturning = 0;
        end else if (mVending) begin
            e.reject = c;
            if (a) begin
                mVending = 0;
                if (mCredit > 0) begin
                    e.cpulse   = 1;
                    e.cvalue   = mCredit;
                    mCredit    = 0;
                    mReturning = 1;
                end
            end
        end else begin
            accept   = c && (mCredit + v <= MAXC);
            e.reject = c && !accept;
            add      = accept ? v : 0;
            if (mCredit == 0) begin
                mCredit += add;
                e.insuf  = s;
            end else if (k || tmo) begin
                e.cpulse   = 1;
                e.cvalue   = mCredit + add;
                mCredit    = 0;
                mReturning = 1;
            end else if (s && mCredit >= prices[it]) begin
                mCredit  = mCredit - prices[it] + add;
                mVending = 1;
                mItem    = it;
            end else begin
                e.insuf  = s;
                mCredit += add;
            end
        end
        if (holding && !(c || s || k || tmo)) mIdle++;
        else mIdle = 0;
        e.credit = mCredit;
        e.vreq   = mVending;
        e.vitem  = mItem;
        e.busy   = mVending || mReturning;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit c, input int v, input bit s, input int it, input bit k, input bit a);
        @(negedge clk);
        coin_pulse = c;
        coin_value = 8'(v);
        sel_valid  = s;
        sel_item   = 2'(it);
        cancel     = k;
        vend_ack   = a;
        modelStep(c, v, s, it, k, a);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n      = 1'b0;
        coin_pulse = 0; coin_value = 0; sel_valid = 0; sel_item = 0; cancel = 0; vend_ack = 0;
        modelReset();
        #1;
        checkOutput("async_reset_vend_req", vend_req, 0);
        checkOutput("async_reset_credit", credit, 0);
        checkOutput("async_reset_busy", busy, 0);
        expQ.push_back(zeroExp());
        @(negedge clk);
        rst_n = 1'b1;
        modelStep(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: independent of stimulus, compares every presented output cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("credit", credit, e.credit);
                checkOutput("vend_req", vend_req, e.vreq);
                checkOutput("vend_item", vend_item, e.vitem);
                checkOutput("change_pulse", change_pulse, e.cpulse);
                checkOutput("change_value", change_value, e.cvalue);
                checkOutput("coin_reject", coin_reject, e.reject);
                checkOutput("insufficient", insufficient, e.insuf);
                checkOutput("busy", busy, e.busy);
            end
        end
    end

    bit rc, rs, rk, ra;
    int rv, ri;

    initial begin
        rst_n = 1'b0;
        coin_pulse = 0; coin_value = 0; sel_valid = 0; sel_item = 0; cancel = 0; vend_ack = 0;
        modelReset();
        resetDut();

        // Coins 5,2 back to back, buy item 1, selection and coin during dispense, then change of 2
        applyStimulus(1, 5, 0, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(1, 5, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idleCycles(2);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idleCycles(2);

        // Insufficient credit, then refund via cancel; stray ack and cancel in idle ignored
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        idleCycles(1);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 1, 2, 0, 0);

        // Credit ceiling: 48 then 5 rejected, 2 lands exactly on 50; oversized coin rejected
        applyStimulus(1, 25, 0, 0, 0, 0);
        applyStimulus(1, 20, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 0, 0, 0);
        applyStimulus(1, 2, 0, 0, 0, 0);
        applyStimulus(1, 255, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idleCycles(1);

        // Cancel beats selection in the same cycle; cancel with a coin refunds both
        applyStimulus(1, 6, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        idleCycles(1);
        applyStimulus(1, 4, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 0, 1, 0);
        idleCycles(1);

        // Exact-price purchase leaves zero credit; coin with selection uses pre-coin credit
        applyStimulus(1, 7, 0, 0, 0, 0);
        applyStimulus(1, 2, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idleCycles(1);
        applyStimulus(1, 10, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        idleCycles(1);

        // Reset in the middle of a dispense drops the request and the credit
        applyStimulus(1, 12, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 0, 0);
        idleCycles(1);
        resetDut();

        // Long inactivity with credit held
        applyStimulus(1, 5, 0, 0, 0, 0);
        idleCycles(1100);
        applyStimulus(0, 0, 0, 0, 1, 0);
        idleCycles(2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rc = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
            rs = ($urandom_range(0, 9) < 2);
            ri = int'($urandom_range(0, 3));
            rk = ($urandom_range(0, 29) == 0);
            ra = ($urandom_range(0, 9) < 3);
            applyStimulus(rc, rc ? rv : 0, rs, ri, rk, ra);
        end
        idleCycles(3);

        @(posedge clk);
        #2;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
